// File: rtl/excp_ctrl_if.sv
// Bundle between the writeback stage, the CSR file and the exception
// controller. The pipeline/CSR side drives the inputs (master) and the
// controller returns the commit, flush and redirect controls (slave).
interface excp_ctrl_if;
  logic        stallreq_axi;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [7:0]  wb_excp_vec;
  logic [31:0] wb_error_va;
  logic        has_int_in;
  logic [31:0] csr_new_pc;
  logic [63:0] csr_vec_o;
  logic [31:0] csr_pc_o;
  logic [31:0] csr_error_va_o;
  logic        wb_ready_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;
  logic [15:0] excp_count_o;

  modport master (
    output stallreq_axi, wb_valid, wb_pc, wb_excp_vec, wb_error_va,
           has_int_in, csr_new_pc,
    input  csr_vec_o, csr_pc_o, csr_error_va_o, wb_ready_o, flush_o,
           redirect_valid_o, redirect_pc_o, busy_o, excp_count_o
  );

  modport slave (
    input  stallreq_axi, wb_valid, wb_pc, wb_excp_vec, wb_error_va,
           has_int_in, csr_new_pc,
    output csr_vec_o, csr_pc_o, csr_error_va_o, wb_ready_o, flush_o,
           redirect_valid_o, redirect_pc_o, busy_o, excp_count_o
  );
endinterface

// File: rtl/excp_ctrl.sv
// Exception commit controller: captures an excepting writeback instruction,
// presents it to the CSR file for one non-stalled cycle, then flushes the
// pipeline and redirects fetch to the CSR-supplied target for FLUSH_CYCLES.
module excp_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  excp_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [7:0]  vec_q;
  logic [31:0] pc_q;
  logic [31:0] va_q;
  logic [31:0] redir_q;
  logic [3:0]  fcnt_q;
  logic [15:0] cnt_q, cnt_d;
  logic        trigger;
  logic        capture;
  logic        commit_done;

  // Commit counter never wraps so software can tell "many" from "few".
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign trigger     = bus.wb_valid & ((|bus.wb_excp_vec) | bus.has_int_in);
  assign capture     = (state_q == S_IDLE) & trigger;
  assign commit_done = (state_q == S_COMMIT) & ~bus.stallreq_axi;
  assign cnt_d       = commit_done ? sat_inc(cnt_q) : cnt_q;

  // Next-state logic; writeback inputs only matter while IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (trigger) state_d = bus.stallreq_axi ? S_WAIT : S_COMMIT;
      S_WAIT:   if (!bus.stallreq_axi) state_d = S_COMMIT;
      S_COMMIT: if (!bus.stallreq_axi) state_d = S_FLUSH;
      S_FLUSH:  if (fcnt_q == 4'd1) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, captured exception record, redirect target and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      pc_q    <= '0;
      va_q    <= '0;
      redir_q <= '0;
      fcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        // A pending interrupt rides on the int bit of the recorded vector.
        vec_q <= {bus.wb_excp_vec[7:1], bus.wb_excp_vec[0] | bus.has_int_in};
        pc_q  <= bus.wb_pc;
        va_q  <= bus.wb_error_va;
      end
      if (commit_done) begin
        redir_q <= bus.csr_new_pc;
        fcnt_q  <= FLUSH_LOAD;
      end else if (state_q == S_FLUSH) begin
        fcnt_q <= fcnt_q - 4'd1;
      end
    end
  end

  // Output decode: the CSR record is visible only while committing and the
  // redirect target only while flushing.
  always_comb begin
    bus.csr_vec_o        = (state_q == S_COMMIT) ? {56'd0, vec_q} : 64'd0;
    bus.csr_pc_o         = (state_q == S_COMMIT) ? pc_q : 32'd0;
    bus.csr_error_va_o   = (state_q == S_COMMIT) ? va_q : 32'd0;
    bus.wb_ready_o       = (state_q == S_IDLE);
    bus.busy_o           = (state_q != S_IDLE);
    bus.flush_o          = (state_q == S_FLUSH);
    bus.redirect_valid_o = (state_q == S_FLUSH);
    bus.redirect_pc_o    = (state_q == S_FLUSH) ? redir_q : 32'd0;
    bus.excp_count_o     = cnt_q;
  end

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed bench for excp_ctrl: a vector table walks the main sequences on a
// FLUSH_CYCLES=2 instance; hand-written sequences cover resets mid-sequence,
// flush length and counter saturation on a FLUSH_CYCLES=4 instance.
module tb_excp_ctrl;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  excp_ctrl_if if_a();
  excp_ctrl_if if_b();

  excp_ctrl dut  (.clk(clk), .reset(reset_a), .bus(if_a.slave));
  excp_ctrl #(.FLUSH_CYCLES(4)) dut4 (.clk(clk), .reset(reset_b), .bus(if_b.slave));

  typedef struct {
    logic        stall;
    logic        valid;
    logic [7:0]  ev;
    logic        intr;
    logic [31:0] pc;
    logic [31:0] va;
    logic [31:0] npc;
    logic [7:0]  x_vec;
    logic [31:0] x_pc;
    logic [31:0] x_va;
    logic        x_rdy;
    logic        x_fl;
    logic [31:0] x_rpc;
    logic [15:0] x_cnt;
  } row_t;

  localparam int NROWS = 27;
  row_t tbl [NROWS];

  function automatic row_t mk(input logic s, input logic v, input logic [7:0] ev,
                              input logic it, input logic [31:0] pc, input logic [31:0] va,
                              input logic [31:0] npc, input logic [7:0] xv,
                              input logic [31:0] xpc, input logic [31:0] xva,
                              input logic xr, input logic xf, input logic [31:0] xrpc,
                              input logic [15:0] xc);
    row_t r;
    r.stall = s;   r.valid = v;   r.ev = ev;    r.intr = it;
    r.pc = pc;     r.va = va;     r.npc = npc;
    r.x_vec = xv;  r.x_pc = xpc;  r.x_va = xva; r.x_rdy = xr;
    r.x_fl = xf;   r.x_rpc = xrpc; r.x_cnt = xc;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic s, input logic v, input logic [7:0] ev,
                         input logic it, input logic [31:0] pc, input logic [31:0] va,
                         input logic [31:0] npc);
    if_a.stallreq_axi = s;  if_a.wb_valid = v;    if_a.wb_excp_vec = ev;
    if_a.has_int_in = it;   if_a.wb_pc = pc;      if_a.wb_error_va = va;
    if_a.csr_new_pc = npc;
  endtask

  task automatic drive_b(input logic s, input logic v, input logic [7:0] ev,
                         input logic it, input logic [31:0] npc);
    if_b.stallreq_axi = s;  if_b.wb_valid = v;    if_b.wb_excp_vec = ev;
    if_b.has_int_in = it;   if_b.wb_pc = 32'h1C00F000; if_b.wb_error_va = 32'h0;
    if_b.csr_new_pc = npc;
  endtask

  // One full exception on the FLUSH_CYCLES=4 instance, flush bounded by a budget.
  task automatic excp_b(input string nm);
    int n;
    drive_b(0, 1, 8'h04, 0, 32'h0);
    tick();
    drive_b(0, 0, 8'h00, 0, 32'h1C00E000);
    tick();
    n = 0;
    while (if_b.flush_o && n < 20) begin
      n++;
      tick();
    end
    chk({nm, " flush_len"}, 64'(n), 64'd4);
  endtask

  task automatic chk_reset_state(input string nm, input logic [63:0] vec, input logic [31:0] pc,
                                 input logic [31:0] va, input logic rdy, input logic busy,
                                 input logic fl, input logic rv, input logic [31:0] rpc,
                                 input logic [15:0] cnt);
    chk({nm, " state"}, {vec, pc, va, rdy, busy, fl, rv, rpc, cnt},
        {64'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0});
  endtask

  initial begin
    drive_a(0, 0, 8'h00, 0, 32'h0, 32'h0, 32'h0);
    drive_b(0, 0, 8'h00, 0, 32'h0);
    reset_a = 1'b1;
    reset_b = 1'b1;

    //               stall valid ev     int pc            va            npc            x_vec  x_pc          x_va          rdy fl x_rpc         cnt
    tbl[0]  = mk(0, 1, 8'h04, 0, 32'h1C000100, 32'h0,        32'h0,        8'h04, 32'h1C000100, 32'h0,        0, 0, 32'h0,        16'd0);
    tbl[1]  = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h1C008000, 8'h00, 32'h0,        32'h0,        0, 1, 32'h1C008000, 16'd1);
    tbl[2]  = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        0, 1, 32'h1C008000, 16'd1);
    tbl[3]  = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        1, 0, 32'h0,        16'd1);
    tbl[4]  = mk(0, 1, 8'h00, 0, 32'h1C000180, 32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        1, 0, 32'h0,        16'd1);
    tbl[5]  = mk(1, 1, 8'h80, 0, 32'h1C000200, 32'h3,        32'h0,        8'h00, 32'h0,        32'h0,        0, 0, 32'h0,        16'd1);
    tbl[6]  = mk(1, 1, 8'h04, 0, 32'h1C000204, 32'h8,        32'h0,        8'h00, 32'h0,        32'h0,        0, 0, 32'h0,        16'd1);
    tbl[7]  = mk(1, 0, 8'h00, 1, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        0, 0, 32'h0,        16'd1);
    tbl[8]  = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h80, 32'h1C000200, 32'h3,        0, 0, 32'h0,        16'd1);
    tbl[9]  = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h1C009000, 8'h00, 32'h0,        32'h0,        0, 1, 32'h1C009000, 16'd2);
    tbl[10] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        0, 1, 32'h1C009000, 16'd2);
    tbl[11] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        1, 0, 32'h0,        16'd2);
    tbl[12] = mk(0, 1, 8'h00, 1, 32'h1C000300, 32'h0,        32'h0,        8'h01, 32'h1C000300, 32'h0,        0, 0, 32'h0,        16'd2);
    tbl[13] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h1C00A000, 8'h00, 32'h0,        32'h0,        0, 1, 32'h1C00A000, 16'd3);
    tbl[14] = mk(0, 1, 8'h04, 1, 32'h1C000304, 32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        0, 1, 32'h1C00A000, 16'd3);
    tbl[15] = mk(0, 1, 8'h04, 1, 32'h1C000308, 32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        1, 0, 32'h0,        16'd3);
    tbl[16] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        1, 0, 32'h0,        16'd3);
    tbl[17] = mk(0, 1, 8'h04, 0, 32'h1C000400, 32'h0,        32'h0,        8'h04, 32'h1C000400, 32'h0,        0, 0, 32'h0,        16'd3);
    tbl[18] = mk(1, 0, 8'h00, 0, 32'h0,        32'h0,        32'h1C00BBBB, 8'h04, 32'h1C000400, 32'h0,        0, 0, 32'h0,        16'd3);
    tbl[19] = mk(1, 0, 8'h00, 0, 32'h0,        32'h0,        32'h1C00BBBB, 8'h04, 32'h1C000400, 32'h0,        0, 0, 32'h0,        16'd3);
    tbl[20] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h1C00B000, 8'h00, 32'h0,        32'h0,        0, 1, 32'h1C00B000, 16'd4);
    tbl[21] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        0, 1, 32'h1C00B000, 16'd4);
    tbl[22] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        1, 0, 32'h0,        16'd4);
    tbl[23] = mk(0, 1, 8'hA6, 1, 32'h1C000500, 32'h12345678, 32'h0,        8'hA7, 32'h1C000500, 32'h12345678, 0, 0, 32'h0,        16'd4);
    tbl[24] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h1C00C000, 8'h00, 32'h0,        32'h0,        0, 1, 32'h1C00C000, 16'd5);
    tbl[25] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        0, 1, 32'h1C00C000, 16'd5);
    tbl[26] = mk(0, 0, 8'h00, 0, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        32'h0,        1, 0, 32'h0,        16'd5);

    tick();
    tick();
    reset_a = 1'b0;
    reset_b = 1'b0;
    chk_reset_state("reset_a", if_a.csr_vec_o, if_a.csr_pc_o, if_a.csr_error_va_o, if_a.wb_ready_o,
                    if_a.busy_o, if_a.flush_o, if_a.redirect_valid_o, if_a.redirect_pc_o, if_a.excp_count_o);
    chk_reset_state("reset_b", if_b.csr_vec_o, if_b.csr_pc_o, if_b.csr_error_va_o, if_b.wb_ready_o,
                    if_b.busy_o, if_b.flush_o, if_b.redirect_valid_o, if_b.redirect_pc_o, if_b.excp_count_o);

    // Vector table on the FLUSH_CYCLES=2 instance.
    for (int i = 0; i < NROWS; i++) begin
      drive_a(tbl[i].stall, tbl[i].valid, tbl[i].ev, tbl[i].intr, tbl[i].pc, tbl[i].va, tbl[i].npc);
      tick();
      chk($sformatf("r%0d vec", i), if_a.csr_vec_o, {56'd0, tbl[i].x_vec});
      chk($sformatf("r%0d pc", i), if_a.csr_pc_o, tbl[i].x_pc);
      chk($sformatf("r%0d va", i), if_a.csr_error_va_o, tbl[i].x_va);
      chk($sformatf("r%0d rdy_busy", i), {if_a.wb_ready_o, if_a.busy_o}, {tbl[i].x_rdy, ~tbl[i].x_rdy});
      chk($sformatf("r%0d flush_rv", i), {if_a.flush_o, if_a.redirect_valid_o}, {tbl[i].x_fl, tbl[i].x_fl});
      chk($sformatf("r%0d rpc", i), if_a.redirect_pc_o, tbl[i].x_rpc);
      chk($sformatf("r%0d cnt", i), if_a.excp_count_o, tbl[i].x_cnt);
    end

    // Reset while waiting on a stall: sequence abandoned, no commit afterwards.
    drive_a(1, 1, 8'h04, 0, 32'h1C000600, 32'h0, 32'h0);
    tick();
    chk("wait busy", if_a.busy_o, 1'b1);
    drive_a(1, 0, 8'h00, 0, 32'h0, 32'h0, 32'h1C00D000);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    chk("wait rst", {if_a.wb_ready_o, if_a.flush_o, if_a.excp_count_o}, {1'b1, 1'b0, 16'd0});
    drive_a(0, 0, 8'h00, 0, 32'h0, 32'h0, 32'h1C00D000);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("wait quiet%0d", k),
          {if_a.csr_vec_o, if_a.flush_o, if_a.redirect_valid_o, if_a.wb_ready_o}, {64'd0, 1'b0, 1'b0, 1'b1});
    end

    // Reset in the commit cycle: no count, no flush.
    drive_a(0, 1, 8'h04, 0, 32'h1C000700, 32'h0, 32'h0);
    tick();
    chk("commit vec", if_a.csr_vec_o, 64'h04);
    drive_a(0, 0, 8'h00, 0, 32'h0, 32'h0, 32'h1C00D000);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    chk("commit rst", {if_a.wb_ready_o, if_a.flush_o, if_a.redirect_valid_o, if_a.excp_count_o},
        {1'b1, 1'b0, 1'b0, 16'd0});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("commit quiet%0d", k), {if_a.flush_o, if_a.redirect_pc_o, if_a.excp_count_o},
          {1'b0, 32'd0, 16'd0});
    end

    // FLUSH_CYCLES=4: flush length, then reset in the second flush cycle.
    excp_b("b1");
    chk("b1 idle", {if_b.wb_ready_o, if_b.redirect_pc_o, if_b.excp_count_o}, {1'b1, 32'd0, 16'd1});
    drive_b(0, 1, 8'h04, 0, 32'h0);
    tick();
    drive_b(0, 0, 8'h00, 0, 32'h1C00E100);
    tick();
    chk("b2 flush1", {if_b.flush_o, if_b.redirect_pc_o}, {1'b1, 32'h1C00E100});
    tick();
    chk("b2 flush2", {if_b.flush_o, if_b.excp_count_o}, {1'b1, 16'd2});
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    chk("b2 rst", {if_b.flush_o, if_b.redirect_valid_o, if_b.excp_count_o, if_b.wb_ready_o},
        {1'b0, 1'b0, 16'd0, 1'b1});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("b2 quiet%0d", k), {if_b.flush_o, if_b.redirect_valid_o}, 2'b00);
    end

    // Saturation: start the counter just below the top.
    force dut4.cnt_q = 16'hFFFE;
    tick();
    release dut4.cnt_q;
    tick();
    chk("sat preload", if_b.excp_count_o, 16'hFFFE);
    excp_b("sat1");
    chk("sat1 cnt", if_b.excp_count_o, 16'hFFFF);
    excp_b("sat2");
    chk("sat2 cnt", if_b.excp_count_o, 16'hFFFF);
    excp_b("sat3");
    chk("sat3 cnt", if_b.excp_count_o, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
